// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - memory-side responder with fixed wait states for the CPU load/store channel
//
// Purpose:
//   Accepts one load/store request at a time and counts WAIT_CYC wait states.
//   It then performs the access on an internal word array.
//   The response is held until the requester accepts it.
//   Optional byte-lane write strobes are enabled by defining CPU_MEM_BYTE_STROBE_EN.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_vld    request valid
//   req_wr     1 = write, 0 = read
//   req_addr   word address
//   req_wdata  write data
//   req_be     byte-lane write enables (only with CPU_MEM_BYTE_STROBE_EN)
//   req_rdy    responder idle and able to accept a request
//   rsp_vld    response valid
//   rsp_rdy    requester accepts the response
//   rsp_rdata  read data (0 for writes and out-of-range accesses)
//   rsp_err    address was out of range

module cpu_mem_responder #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_vld,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef CPU_MEM_BYTE_STROBE_EN
    input  logic [DATA_W/8-1:0] req_be,
`endif
    output logic              req_rdy,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              lat_wr;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
`ifdef CPU_MEM_BYTE_STROBE_EN
    logic [DATA_W/8-1:0] lat_be;
`endif

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic              do_access;
    logic [DATA_W-1:0] wmask;

    // The extra top bit keeps the compare valid when DEPTH == 2**ADDR_W.
    assign in_range  = ({1'b0, lat_addr} < (ADDR_W+1)'(DEPTH));
    assign idx       = lat_addr[IDX_W-1:0];
    assign do_access = (state == ST_WAIT) && (cnt == 4'd0);

    always_comb begin
        wmask = '1;
`ifdef CPU_MEM_BYTE_STROBE_EN
        for (int i = 0; i < DATA_W/8; i++) begin
            wmask[8*i +: 8] = {8{lat_be[i]}};
        end
`endif
    end

    // Array contents survive reset. An asserted reset has already forced the FSM out of ST_WAIT,
    // so an uncommitted write can never land.
    always_ff @(posedge clk) begin
        if (do_access && lat_wr && in_range) begin
            mem[idx] <= (mem[idx] & ~wmask) | (lat_wdata & wmask);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            req_rdy   <= 1'b1;
            rsp_vld   <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            lat_wr    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
`ifdef CPU_MEM_BYTE_STROBE_EN
            lat_be    <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_vld) begin
                        lat_wr    <= req_wr;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
`ifdef CPU_MEM_BYTE_STROBE_EN
                        lat_be    <= req_be;
`endif
                        cnt       <= 4'(WAIT_CYC);
                        req_rdy   <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rsp_vld <= 1'b1;
                        rsp_err <= !in_range;
                        if (in_range && !lat_wr) begin
                            rsp_rdata <= mem[idx];
                        end else begin
                            rsp_rdata <= '0;
                        end
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // req_rdy rises only on leaving RESP, so IDLE always lasts at least one cycle.
                    if (rsp_rdy) begin
                        rsp_vld   <= 1'b0;
                        rsp_rdata <= '0;
                        rsp_err   <= 1'b0;
                        req_rdy   <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    req_rdy <= 1'b1;
                    rsp_vld <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - self-checking bench for cpu_mem_responder against a word-array reference model

module tb_cpu_mem_responder;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
`ifdef CPU_MEM_BYTE_STROBE_EN
    localparam int WC     = 0;
    localparam bit STROBE = 1'b1;
`else
    localparam int WC     = 2;
    localparam bit STROBE = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              req_vld;
    logic              req_wr;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
`ifdef CPU_MEM_BYTE_STROBE_EN
    logic [3:0]        req_be;
`endif
    logic              req_rdy;
    logic              rsp_vld;
    logic              rsp_rdy;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [0:DEPTH-1];

    cpu_mem_responder #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .WAIT_CYC(WC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_vld  (req_vld),
        .req_wr   (req_wr),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
`ifdef CPU_MEM_BYTE_STROBE_EN
        .req_be   (req_be),
`endif
        .req_rdy  (req_rdy),
        .rsp_vld  (rsp_vld),
        .rsp_rdy  (rsp_rdy),
        .rsp_rdata(rsp_rdata),
        .rsp_err  (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the edge where the response is taken.
    task automatic txn(input bit wr, input logic [15:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, input int hold);
        logic [31:0] exp_rd;
        logic        exp_err;
        logic [3:0]  eff_be;
        logic [31:0] r;
        int          n;
        int          lat;

        eff_be  = STROBE ? be : 4'hF;
        exp_err = (int'(addr) >= DEPTH);
        exp_rd  = 32'h0;
        if (!exp_err && !wr) exp_rd = model[addr[7:0]];
        if (!exp_err && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (eff_be[b]) model[addr[7:0]][8*b +: 8] = wdata[8*b +: 8];
            end
        end

        req_vld   = 1'b1;
        req_wr    = wr;
        req_addr  = addr;
        req_wdata = wdata;
`ifdef CPU_MEM_BYTE_STROBE_EN
        req_be    = be;
`endif
        n = 0;
        while (!req_rdy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_timeout", 64'(n < 50), 64'd1);
        @(posedge clk); #1;

        // Scramble request inputs; the latched copy must be used.
        r = $urandom;
        req_wr    = r[0];
        r = $urandom;
        req_addr  = r[15:0];
        req_wdata = $urandom;
`ifdef CPU_MEM_BYTE_STROBE_EN
        r = $urandom;
        req_be    = r[3:0];
`endif
        lat = 0;
        while (!rsp_vld && lat < 50) begin
            check("busy_req_rdy", 64'(req_rdy), 64'd0);
            @(posedge clk); #1;
            lat++;
        end
        req_vld = 1'b0;
        check("latency", 64'(lat), 64'(WC + 1));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rd));
        check("rsp_err", 64'(rsp_err), 64'(exp_err));
        check("resp_req_rdy", 64'(req_rdy), 64'd0);

        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_vld", 64'(rsp_vld), 64'd1);
            check("hold_rdata", 64'(rsp_rdata), 64'(exp_rd));
            check("hold_err", 64'(rsp_err), 64'(exp_err));
            check("hold_req_rdy", 64'(req_rdy), 64'd0);
        end

        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        rsp_rdy = 1'b0;
        check("idle_vld", 64'(rsp_vld), 64'd0);
        check("idle_req_rdy", 64'(req_rdy), 64'd1);
        check("idle_rdata", 64'(rsp_rdata), 64'd0);
        check("idle_err", 64'(rsp_err), 64'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic [31:0] r2;
        logic [15:0] a;

        rst_n     = 1'b0;
        req_vld   = 1'b0;
        req_wr    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
`ifdef CPU_MEM_BYTE_STROBE_EN
        req_be    = 4'h0;
`endif
        rsp_rdy   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset_req_rdy", 64'(req_rdy), 64'd1);
        check("reset_rsp_vld", 64'(rsp_vld), 64'd0);
        check("reset_rdata", 64'(rsp_rdata), 64'd0);
        check("reset_err", 64'(rsp_err), 64'd0);

        // Give every word a known value.
        for (int i = 0; i < DEPTH; i++) begin
            txn(1'b1, 16'(i), $urandom, 4'hF, 0);
        end

        // Write then read back, with backpressure on the read.
        txn(1'b1, 16'h0010, 32'hDEADBEEF, 4'hF, 0);
        txn(1'b0, 16'h0010, 32'h0, 4'h0, 5);

        // Out-of-range write must not alias onto word 0.
        txn(1'b1, 16'h0100, 32'h12345678, 4'hF, 1);
        txn(1'b0, 16'h0000, 32'h0, 4'h0, 0);
        txn(1'b0, 16'hFFFF, 32'h0, 4'h0, 0);
        txn(1'b0, 16'h00FF, 32'h0, 4'h0, 0);

`ifdef CPU_MEM_BYTE_STROBE_EN
        txn(1'b1, 16'h0030, 32'hFFFFFFFF, 4'b1111, 0);
        txn(1'b1, 16'h0030, 32'h00000000, 4'b0101, 0);
        txn(1'b0, 16'h0030, 32'h0, 4'h0, 0);
        check("strobe_model", 64'(model[8'h30]), 64'hFF00FF00);
        txn(1'b1, 16'h0030, 32'h12345678, 4'b0000, 0);
        txn(1'b0, 16'h0030, 32'h0, 4'h0, 0);
`endif

        // Reset in the middle of a write's wait period.
        req_vld   = 1'b1;
        req_wr    = 1'b1;
        req_addr  = 16'h0020;
        req_wdata = 32'h00000055;
`ifdef CPU_MEM_BYTE_STROBE_EN
        req_be    = 4'hF;
`endif
        @(posedge clk); #1;
        req_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req_rdy", 64'(req_rdy), 64'd1);
        check("midrst_rsp_vld", 64'(rsp_vld), 64'd0);
        check("midrst_rdata", 64'(rsp_rdata), 64'd0);
        check("midrst_err", 64'(rsp_err), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        txn(1'b0, 16'h0020, 32'h0, 4'h0, 0);

        // Randomized traffic, including out-of-range addresses.
        for (int i = 0; i < 80; i++) begin
            r  = $urandom;
            r2 = $urandom;
            a  = (r[7:4] == 4'hF) ? r2[15:0] : 16'($urandom_range(0, 299));
            txn(r[0], a, $urandom, r[11:8], int'(r[3:2]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the CPU memory control interface: the target end of the CPU's load/store request channel.
- Accepts one request at a time over a valid/ready handshake and applies a fixed number of wait states.
- Performs the read or write on an internal word array, then returns a response that is held until the CPU accepts it.
- Serves as the data-memory model behind cpu_memory_control in simulation; also usable as an on-chip scratch RAM.

Parameters:
- ADDR_W, 16: request address width (word address).
- DATA_W, 32: data word width.
- DEPTH, 256: number of words in the array; power of two, and DEPTH <= 2^ADDR_W.
- WAIT_CYC, 2: wait states between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_vld  in  1  request valid from the CPU memory control.
- req_wr  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_rdy  out  1  responder can accept a request.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  CPU accepts the response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  address out of range.

Behaviour:
- Reset: rst_n low asynchronously forces state=IDLE, wait counter=0, req_rdy=1, rsp_vld=0, rsp_rdata=0, rsp_err=0. Array contents are not reset.
- Reset mid-transaction abandons the request. A write not yet committed is lost; a committed write stays in the array.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_rdy=1.
  - On req_vld at a rising edge: latch wr/addr/wdata, load counter with WAIT_CYC, go to WAIT.
- WAIT:
  - req_rdy=0.
  - If counter != 0, decrement it and stay in WAIT.
  - If counter == 0, perform the access on this edge and go to RESP.
- Access:
  - In range means addr < DEPTH; the index is addr[log2(DEPTH)-1:0].
  - Read, in range: rsp_rdata <= mem[idx].
  - Write, in range: mem[idx] <= wdata and rsp_rdata <= 0.
  - Out of range: no array change, rsp_rdata <= 0, rsp_err <= 1; otherwise rsp_err <= 0.
- RESP:
  - rsp_vld=1 and req_rdy=0; rsp_rdata and rsp_err are held stable.
  - On rsp_rdy: go to IDLE, clear rsp_vld, rsp_rdata=0, rsp_err=0.
  - While rsp_rdy is low, stay in RESP indefinitely.
- Latency: with the request accepted at edge E, rsp_vld rises after edge E+WAIT_CYC+1. With WAIT_CYC=0 this is 1 cycle.
- Throughput: at most one request per WAIT_CYC+3 cycles. IDLE is always visited for at least one cycle between transactions, so there is no back-to-back acceptance in the RESP->IDLE cycle.
- req_vld while req_rdy=0 is ignored; the requester must hold its request until it sees req_rdy.
- Latched request fields are immune to input changes after acceptance.
- Read-after-write to the same address in the next transaction returns the new data.

Optional Feature:
- Macro: CPU_MEM_BYTE_STROBE_EN.
- Defined:
  - Adds input port req_be, width DATA_W/8; DATA_W must be a multiple of 8.
  - Writes update only the byte lanes with be[i]=1; be=0 completes as a normal write response with no array change.
  - Reads ignore req_be.
  - req_be is latched with the other request fields.
- Not defined: no req_be port; writes are full-word.

Test Plan:
- Reset then idle: after rst_n deasserts, req_rdy=1, rsp_vld=0, rsp_rdata=0, rsp_err=0.
- WAIT_CYC=2: write addr 0x0010 data 0xDEADBEEF, then read 0x0010 → write response rsp_vld 3 cycles after acceptance with rdata=0, err=0; read returns 0xDEADBEEF 3 cycles after acceptance.
- Backpressure: hold rsp_rdy=0 for 5 cycles during a read of 0x0010 → rsp_vld and rsp_rdata stay stable and req_rdy=0 throughout; releasing rsp_rdy → IDLE the next cycle.
- Out of range with DEPTH=256: write 0x0100 data 0x12345678 → rsp_err=1, rdata=0; subsequent read of 0x0000 is unchanged.
- Reset mid-WAIT on a write to 0x0020 data 0x55 → outputs return to reset values immediately; a later read of 0x0020 returns its prior value.
- With CPU_MEM_BYTE_STROBE_EN, WAIT_CYC=0: write 0xFFFFFFFF with be=4'b1111, then 0x00000000 with be=4'b0101, then read → 0xFF00FF00, each response 1 cycle after acceptance.
